fifo_srl_prog: RTL

- Parametrised first-word fall-through (FWFT) FIFO built on a shift-register-LUT store. It is the next generation of the team's basic SRL stream FIFO.
- Adds an occupancy count, programmable almost-full and almost-empty flags, and a synchronous flush.
- Sits between pipelined HLS stages. Producers use the flags for early back-pressure; the flush drains a stream between kernel invocations without a global reset.

---
 rtl/fifo_srl_prog.sv | 59 +++++
 1 files changed

// File: rtl/fifo_srl_prog.sv
// fifo_srl_prog: FWFT shift-register FIFO with occupancy count, programmable almost-full/almost-empty flags and flush
module fifo_srl_prog #(
  parameter MEM_STYLE  = "shiftreg",
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int PROG_FULL  = DEPTH - 2,
  parameter int PROG_EMPTY = 1,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  prog_full,
  output logic                  prog_empty
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_srl_prog: DEPTH must be at least 2");
  end
  if (MEM_STYLE != "shiftreg") begin : g_bad_style
    $error("fifo_srl_prog: only shiftreg MEM_STYLE is supported");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr, rd;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic [AW-1:0]         head;
  assign wr = if_write & if_write_ce & if_full_n;
  assign rd = if_read & if_read_ce & if_empty_n;
  always_comb begin
    cnt_nxt = (reset | flush) ? '0 :
              (wr & ~rd)      ? count + 1'b1 :
              (rd & ~wr)      ? count - 1'b1 : count;
  end
  // head sits at count-1; pinned to slot 0 while empty so the index stays in range
  assign head    = (count == '0) ? '0 : AW'(count - 1'b1);
  assign if_dout = mem[head];
  always_ff @(posedge clk) begin
    count      <= cnt_nxt;
    if_full_n  <= cnt_nxt != CNT_WIDTH'(DEPTH);
    if_empty_n <= cnt_nxt != '0;
    prog_full  <= cnt_nxt >= CNT_WIDTH'(PROG_FULL);
    prog_empty <= cnt_nxt <= CNT_WIDTH'(PROG_EMPTY);
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end
endmodule
